// File: rtl/approx_div_pkg.sv
// Shared definitions for the approximate sequential divider.
//   - FSM state encoding (IDLE -> CALC -> DONE)
//   - Bit-level cell equations for exact and approximate borrow/remainder cells
//   - approx_cells(): number of approximate low cells used by a given row
package approx_div_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    CALC = ST_CALC,
    DONE = ST_DONE
  } state_t;

  // Exact full-subtractor borrow.
  function automatic logic exact_bout(input logic a, input logic b, input logic bin);
    return (~a & bin) | (~a & b) | (b & bin);
  endfunction

  // Exact restoring remainder: difference when the row subtracts, else pass-through.
  function automatic logic exact_rout(input logic a, input logic b, input logic bin,
                                      input logic qs);
    return qs ? (a ^ b ^ bin) : a;
  endfunction

  // Approximate borrow: only propagates an incoming borrow, never generates one.
  function automatic logic approx_bout(input logic a, input logic b, input logic bin);
    return bin & (b | ~a);
  endfunction

  // Approximate remainder: OR-based, bounded 2-bit error per cell.
  function automatic logic approx_rout(input logic a, input logic b, input logic bin,
                                       input logic qs);
    return a | (qs & (b ^ bin));
  endfunction

  // Approximate cells in row k: rows below exact_rows are exact, then the count
  // grows by one per row until clamped at pa.
  function automatic int approx_cells(input int k, input int pa, input int exact_rows);
    int n;
    n = k - exact_rows + 1;
    if (n < 0) n = 0;
    if (n > pa) n = pa;
    return n;
  endfunction

endpackage

// File: rtl/approx_div_row.sv
// One combinational row of the restoring divider array.
//   x     [WIDTH:0]   partial remainder with next dividend bit appended
//   y     [WIDTH-1:0] divisor
//   mask  [WIDTH-1:0] 1 = use the approximate cell at that bit position
//   qs    quotient bit produced by this row
//   rout  [WIDTH-1:0] next partial remainder
module approx_div_row
  import approx_div_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH:0]   x,
  input  logic [WIDTH-1:0] y,
  input  logic [WIDTH-1:0] mask,
  output logic             qs,
  output logic [WIDTH-1:0] rout
);

  logic [WIDTH:0] bc;

  // NOTE: every variable written here gets a full default first, so no path
  // can leave a value unassigned and infer a latch.
  always_comb begin
    bc   = '0;
    rout = '0;
    // Borrow chain over x[WIDTH-1:0] - y with borrow-in 0.
    for (int i = 0; i < WIDTH; i++) begin
      bc[i+1] = mask[i] ? approx_bout(x[i], y[i], bc[i])
                        : exact_bout(x[i], y[i], bc[i]);
    end
    // The top bit of x set means the partial remainder already exceeds y.
    qs = ~bc[WIDTH] | x[WIDTH];
    for (int i = 0; i < WIDTH; i++) begin
      rout[i] = mask[i] ? approx_rout(x[i], y[i], bc[i], qs)
                        : exact_rout(x[i], y[i], bc[i], qs);
    end
  end

endmodule

// File: rtl/approx_seq_divider.sv
// Iterative restoring divider, one quotient bit per cycle on a single shared row.
// 2*WIDTH-bit dividend / WIDTH-bit divisor -> WIDTH-bit quotient and remainder.
// Later rows may use approximate low cells, selected at run time by approx_cols.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   operand handshake (dividend, divisor, approx_cols)
//   out_valid/out_ready result handshake (quotient, remainder, div_by_zero, overflow)
// quotient and remainder are the working shift registers; they are only
// meaningful while out_valid is high.
module approx_seq_divider
  import approx_div_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int EXACT_ROWS = 2,
  parameter int APPROX_MAX = 6
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [2*WIDTH-1:0]         dividend,
  input  logic [WIDTH-1:0]           divisor,
  input  logic [$clog2(WIDTH+1)-1:0] approx_cols,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           quotient,
  output logic [WIDTH-1:0]           remainder,
  output logic                       div_by_zero,
  output logic                       overflow
);

  localparam int PW = $clog2(WIDTH + 1);
  localparam int KW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(WIDTH - 1);
  localparam logic [PW-1:0] PA_MAX = PW'(APPROX_MAX);

  state_t           state, state_next;
  logic [KW-1:0]    k;
  logic [WIDTH-1:0] dvd_lo;
  logic [WIDTH-1:0] dvs;
  logic [PW-1:0]    pa;
  logic [WIDTH-1:0] mask;
  logic             row_qs;
  logic [WIDTH-1:0] row_rout;
  logic             accept;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_ready & in_valid;

  // State register.
  // NOTE: sequential state is assigned with <= so every flop samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (in_valid)    state_next = CALC;
      CALC:    if (k == K_LAST) state_next = DONE;
      DONE:    if (out_ready)   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Row mask: low a_k bits approximate for the current row.
  always_comb begin
    int a_k;
    a_k  = approx_cells(int'(k), int'(pa), EXACT_ROWS);
    mask = '0;
    for (int i = 0; i < WIDTH; i++) begin
      mask[i] = (i < a_k);
    end
  end

  approx_div_row #(.WIDTH(WIDTH)) u_row (
    .x    ({remainder, dvd_lo[WIDTH-1]}),
    .y    (dvs),
    .mask (mask),
    .qs   (row_qs),
    .rout (row_rout)
  );

  // Datapath. Flags are evaluated exactly from the operands at acceptance and
  // stay put until the next acceptance, i.e. after the result is consumed.
  // NOTE: the datapath registers are few and small, so all of them are reset;
  // this also gives the required zero outputs straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k           <= '0;
      dvd_lo      <= '0;
      dvs         <= '0;
      pa          <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else if (accept) begin
      k           <= '0;
      remainder   <= dividend[2*WIDTH-1:WIDTH];
      dvd_lo      <= dividend[WIDTH-1:0];
      dvs         <= divisor;
      pa          <= (approx_cols > PA_MAX) ? PA_MAX : approx_cols;
      quotient    <= '0;
      div_by_zero <= (divisor == '0);
      overflow    <= (dividend[2*WIDTH-1:WIDTH] >= divisor);
    end else if (state == CALC) begin
      k         <= k + 1'b1;
      remainder <= row_rout;
      dvd_lo    <= {dvd_lo[WIDTH-2:0], 1'b0};
      quotient  <= {quotient[WIDTH-2:0], row_qs};
    end
  end

endmodule

// File: tb/tb_approx_seq_divider.sv
// Scoreboard bench for approx_seq_divider (WIDTH=8, default parameters).
// Stimulus pushes the expected result; a monitor pops and compares on each
// accepted output.
module tb_approx_seq_divider;

  localparam int W          = 8;
  localparam int EXACT_ROWS = 2;
  localparam int APPROX_MAX = 6;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [2*W-1:0] dividend = '0;
  logic [W-1:0]   divisor = '0;
  logic [3:0]     approx_cols = '0;
  logic           out_valid;
  logic           out_ready = 1'b1;
  logic [W-1:0]   quotient;
  logic [W-1:0]   remainder;
  logic           div_by_zero;
  logic           overflow;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
    logic         ovf;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  approx_seq_divider #(.WIDTH(W), .EXACT_ROWS(EXACT_ROWS), .APPROX_MAX(APPROX_MAX)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .approx_cols (approx_cols),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .overflow    (overflow)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: the array division evaluated row by row from the cell rules.
  function automatic exp_t model(input logic [2*W-1:0] dvd, input logic [W-1:0] dvs, input int p);
    exp_t     e;
    logic [W-1:0] rem, lo, q, rout;
    logic [W:0]   x, bc;
    logic         qs;
    int           pa, ak;
    pa  = (p > APPROX_MAX) ? APPROX_MAX : p;
    rem = dvd[2*W-1:W];
    lo  = dvd[W-1:0];
    q   = '0;
    for (int k = 0; k < W; k++) begin
      x  = {rem, lo[W-1]};
      lo = lo << 1;
      ak = k - EXACT_ROWS + 1;
      if (ak < 0)  ak = 0;
      if (ak > pa) ak = pa;
      bc = '0;
      for (int i = 0; i < W; i++) begin
        if (i < ak) bc[i+1] = bc[i] & (dvs[i] | ~x[i]);
        else        bc[i+1] = (~x[i] & bc[i]) | (~x[i] & dvs[i]) | (dvs[i] & bc[i]);
      end
      qs = ~bc[W] | x[W];
      for (int i = 0; i < W; i++) begin
        if (i < ak) rout[i] = x[i] | (qs & (dvs[i] ^ bc[i]));
        else        rout[i] = qs ? (x[i] ^ dvs[i] ^ bc[i]) : x[i];
      end
      rem = rout;
      q   = {q[W-2:0], qs};
    end
    e.q   = q;
    e.r   = rem;
    e.dbz = (dvs == '0);
    e.ovf = (dvd[2*W-1:W] >= dvs);
    return e;
  endfunction

  function automatic exp_t mk(input logic [W-1:0] q, input logic [W-1:0] r,
                              input logic dbz, input logic ovf);
    exp_t e;
    e.q = q; e.r = r; e.dbz = dbz; e.ovf = ovf;
    return e;
  endfunction

  // Monitor: compares every accepted result against the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_output: q=0x%0h r=0x%0h with empty scoreboard", quotient, remainder);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("quotient",    32'(quotient),    32'(e.q));
        check("remainder",   32'(remainder),   32'(e.r));
        check("div_by_zero", 32'(div_by_zero), 32'(e.dbz));
        check("overflow",    32'(overflow),    32'(e.ovf));
      end
    end
  end

  task automatic send(input logic [2*W-1:0] dvd, input logic [W-1:0] dvs,
                      input logic [3:0] p, input exp_t e);
    int t = 0;
    @(negedge clk);
    while (!in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      check("accept_timeout", 32'(in_ready), 32'd1);
      return;
    end
    dividend    = dvd;
    divisor     = dvs;
    approx_cols = p;
    in_valid    = 1'b1;
    @(posedge clk);
    sb.push_back(e);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic drain();
    int t = 0;
    while ((sb.size() != 0 || !in_ready) && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    int       lat;
    logic [2*W-1:0] dvd;
    logic [W-1:0]   dvs;
    void'($urandom(32'd2024));

    // Reset state.
    #12;
    check("rst_in_ready",  32'(in_ready),    32'd1);
    check("rst_out_valid", 32'(out_valid),   32'd0);
    check("rst_quotient",  32'(quotient),    32'd0);
    check("rst_remainder", 32'(remainder),   32'd0);
    check("rst_dbz",       32'(div_by_zero), 32'd0);
    check("rst_ovf",       32'(overflow),    32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: exact divide and latency.
    send(16'h1234, 8'h56, 4'd0, mk(8'h36, 8'h10, 1'b0, 1'b0));
    wait_valid(lat);
    check("t1_latency", 32'(lat), 32'd8);
    drain();

    // 2: divide by one, then an overflowing dividend.
    send(16'h00FF, 8'h01, 4'd0, mk(8'hFF, 8'h00, 1'b0, 1'b0));
    drain();
    send(16'h5600, 8'h56, 4'd0, model(16'h5600, 8'h56, 0));
    drain();

    // 3: divide by zero.
    send(16'hABCD, 8'h00, 4'd0, mk(8'hFF, 8'hCD, 1'b1, 1'b1));
    drain();

    // 4: back-pressure holds the result and blocks new operands.
    out_ready = 1'b0;
    send(16'h1234, 8'h56, 4'd0, mk(8'h36, 8'h10, 1'b0, 1'b0));
    wait_valid(lat);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #2;
      check("t4_out_valid", 32'(out_valid), 32'd1);
      check("t4_in_ready",  32'(in_ready),  32'd0);
      check("t4_quotient",  32'(quotient),  32'h36);
      check("t4_remainder", 32'(remainder), 32'h10);
      dividend = 16'(~c);
      divisor  = 8'(c + 3);
      in_valid = 1'b1;
    end
    @(posedge clk);
    #2;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("t4_ready_after", 32'(in_ready),  32'd1);
    check("t4_valid_after", 32'(out_valid), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("t4_ignored_ops", 32'(out_valid), 32'd0);
    check("t4_sb_empty",    32'(sb.size()), 32'd0);

    // 5: reset during row 4 aborts the operation.
    send(16'hABCD, 8'h00, 4'd0, mk(8'hFF, 8'hCD, 1'b1, 1'b1));
    repeat (4) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("t5_in_ready",  32'(in_ready),    32'd1);
    check("t5_out_valid", 32'(out_valid),   32'd0);
    check("t5_quotient",  32'(quotient),    32'd0);
    check("t5_remainder", 32'(remainder),   32'd0);
    check("t5_dbz",       32'(div_by_zero), 32'd0);
    check("t5_ovf",       32'(overflow),    32'd0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    send(16'h1234, 8'h56, 4'd0, mk(8'h36, 8'h10, 1'b0, 1'b0));
    wait_valid(lat);
    check("t5_latency", 32'(lat), 32'd8);
    drain();

    // 6: random operands, p=15 and p=6 must both match the p=6 array.
    for (int i = 0; i < 1000; i++) begin
      dvd = 16'($urandom);
      dvs = 8'($urandom);
      send(dvd, dvs, 4'd15, model(dvd, dvs, 6));
      send(dvd, dvs, 4'd6,  model(dvd, dvs, 6));
    end
    drain();

    // Exact mode against true division, no overflow.
    for (int i = 0; i < 200; i++) begin
      dvs = 8'($urandom_range(1, 255));
      dvd = {8'($urandom_range(0, int'(dvs) - 1)), 8'($urandom)};
      send(dvd, dvs, 4'd0, mk(8'(dvd / 16'(dvs)), 8'(dvd % 16'(dvs)), 1'b0, 1'b0));
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
